// File: rtl/seq_run_pause_ctrl_pkg.sv
// Shared constants for the run/pause digit sequencer: state encoding and
// the fixed digit pattern stepped through during RUN.
package seq_run_pause_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  localparam int SEQ_LEN = 6;

  // Entry 0 sits in the low nibble.
  localparam logic [SEQ_LEN*4-1:0] SEQ_ROM = {4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};

  localparam logic [3:0] LAST_DIGIT = 4'd9;

  function automatic logic [3:0] seq_digit(input logic [2:0] idx);
    if (idx < 3'(SEQ_LEN)) begin
      return SEQ_ROM[4*idx +: 4];
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/seq_run_pause_ctrl_tick_gen.sv
// Free-running step divider: emits a one-cycle tick every TICK_DIV enabled
// clocks. Frozen entirely while en is low.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] d_q;
  logic [DW-1:0] d_d;

  always_comb begin
    d_d = d_q;
    if (en) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + DW'(1);
    end
  end

  assign tick = en && (d_q == D_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/seq_run_pause_ctrl.sv
// Digit sequencer: LAPS passes over the digit pattern, then a blinking pause
// on the last digit, then restart. All outputs are registered.
module seq_run_pause_ctrl
  import seq_run_pause_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int LAPS       = 3,
  parameter int BLINKS     = 2,
  parameter int BLINK_HALF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [3:0] digit,
  output logic       blank,
  output logic       state,
  output logic [1:0] lap,
  output logic       tick,
  output logic       cycle_done
);

  localparam int PAUSE_LEN = 2 * BLINK_HALF * BLINKS;
  localparam int PW        = $clog2(PAUSE_LEN);
  localparam logic [PW-1:0] P_LAST   = PW'(PAUSE_LEN - 1);
  localparam logic [PW-1:0] BH_W     = PW'(BLINK_HALF);
  localparam logic [2:0]    IDX_LAST = 3'(SEQ_LEN - 1);
  localparam logic [1:0]    LAP_LAST = 2'(LAPS - 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    lap_q, lap_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] half_idx;
  logic [3:0]    digit_q, digit_d;
  logic          blank_q, blank_d;
  logic          cycle_done_q, cycle_done_d;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lap_d        = lap_q;
    p_d          = p_q;
    cycle_done_d = 1'b0;

    if (idx_q > IDX_LAST) begin
      // Unreachable index: fall back to the start of RUN immediately.
      state_d = ST_RUN;
      idx_d   = '0;
      p_d     = '0;
    end else if (tick) begin
      case (state_q)
        ST_RUN: begin
          if (idx_q < IDX_LAST) begin
            idx_d = idx_q + 3'd1;
          end else if (lap_q < LAP_LAST) begin
            idx_d = '0;
            lap_d = lap_q + 2'd1;
          end else begin
            state_d = ST_PAUSE;
            lap_d   = '0;
            p_d     = '0;
          end
        end
        ST_PAUSE: begin
          if (p_q == P_LAST) begin
            state_d      = ST_RUN;
            idx_d        = '0;
            p_d          = '0;
            cycle_done_d = 1'b1;
          end else begin
            p_d = p_q + PW'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      endcase
    end

    // Display values follow the state being entered, so they line up with it.
    half_idx = p_d / BH_W;
    digit_d  = (state_d == ST_PAUSE) ? LAST_DIGIT : seq_digit(idx_d);
    blank_d  = (state_d == ST_PAUSE) && !half_idx[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      lap_q        <= '0;
      p_q          <= '0;
      digit_q      <= '0;
      blank_q      <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lap_q        <= lap_d;
      p_q          <= p_d;
      digit_q      <= digit_d;
      blank_q      <= blank_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign digit      = digit_q;
  assign blank      = blank_q;
  assign state      = state_q;
  assign lap        = lap_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_seq_run_pause_ctrl.sv
// Bench for seq_run_pause_ctrl: a default instance and a short-period instance
// run side by side against a tick-count model, plus directed literal checks.
module tb_seq_run_pause_ctrl;

  localparam int TD_A = 4, LAPS_A = 3, BLINKS_A = 2, BH_A = 1;
  localparam int TD_B = 2, LAPS_B = 1, BLINKS_B = 1, BH_B = 2;
  localparam int PER_A = 6 * LAPS_A + 2 * BH_A * BLINKS_A;
  localparam int PER_B = 6 * LAPS_B + 2 * BH_B * BLINKS_B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;

  logic [3:0] digit_a, digit_b;
  logic       blank_a, blank_b, state_a, state_b, tick_a, tick_b, cd_a, cd_b;
  logic [1:0] lap_a, lap_b;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;
  int rom_t[6] = '{0, 2, 4, 5, 7, 9};

  // Model: enabled-clock phase t, completed ticks k, wrap pulse cd.
  int ta = 0, ka = 0, tb = 0, kb = 0;
  bit cda = 1'b0, cdb = 1'b0;

  always #5 clk = ~clk;

  seq_run_pause_ctrl #(
    .TICK_DIV(TD_A), .LAPS(LAPS_A), .BLINKS(BLINKS_A), .BLINK_HALF(BH_A)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .digit(digit_a), .blank(blank_a),
    .state(state_a), .lap(lap_a), .tick(tick_a), .cycle_done(cd_a)
  );

  seq_run_pause_ctrl #(
    .TICK_DIV(TD_B), .LAPS(LAPS_B), .BLINKS(BLINKS_B), .BLINK_HALF(BH_B)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .digit(digit_b), .blank(blank_b),
    .state(state_b), .lap(lap_b), .tick(tick_b), .cycle_done(cd_b)
  );

  always @(posedge clk) begin
    if (reset) begin
      ta <= 0; ka <= 0; cda <= 1'b0;
      tb <= 0; kb <= 0; cdb <= 1'b0;
    end else begin
      cda <= 1'b0;
      cdb <= 1'b0;
      if (en) begin
        ta <= (ta + 1) % TD_A;
        tb <= (tb + 1) % TD_B;
        if (ta == TD_A - 1) begin
          ka  <= ka + 1;
          cda <= ((ka + 1) % PER_A) == 0;
        end
        if (tb == TD_B - 1) begin
          kb  <= kb + 1;
          cdb <= ((kb + 1) % PER_B) == 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int td, input int laps,
                           input int blinks, input int bh, input int t, input int k,
                           input bit cd, input logic [3:0] dg, input logic bl,
                           input logic st, input logic [1:0] lp, input logic tk,
                           input logic cdn);
    int per, m, p, ed, eb, es, el;
    per = 6 * laps + 2 * bh * blinks;
    m = k % per;
    if (m < 6 * laps) begin
      ed = rom_t[m % 6]; eb = 0; es = 0; el = m / 6;
    end else begin
      p  = m - 6 * laps;
      ed = 9; eb = ((p / bh) % 2 == 0) ? 1 : 0; es = 1; el = 0;
    end
    chk({tag, "_digit"}, int'(dg), ed);
    chk({tag, "_blank"}, int'(bl), eb);
    chk({tag, "_state"}, int'(st), es);
    chk({tag, "_lap"}, int'(lp), el);
    chk({tag, "_tick"}, int'(tk), (en && t == td - 1) ? 1 : 0);
    chk({tag, "_cycle_done"}, int'(cdn), int'(cd));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check_dut("a", TD_A, LAPS_A, BLINKS_A, BH_A, ta, ka, cda,
                digit_a, blank_a, state_a, lap_a, tick_a, cd_a);
      check_dut("b", TD_B, LAPS_B, BLINKS_B, BH_B, tb, kb, cdb,
                digit_b, blank_b, state_b, lap_b, tick_b, cd_b);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    reset = 1'b1;
    en = 1'b1;
    step(2);
    armed = 1'b1;
    reset = 1'b0;

    // Free run from reset: pin the timeline of both instances.
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (i == 8)  chk("lit_a_digit_at8", digit_a, 4);
      if (i == 40) chk("lit_a_lap_at40", lap_a, 1);
      if (i == 71) chk("lit_a_blank_at71", blank_a, 0);
      if (i == 72) begin
        chk("lit_a_state_at72", state_a, 1);
        chk("lit_a_digit_at72", digit_a, 9);
        chk("lit_a_blank_at72", blank_a, 1);
      end
      if (i == 76) chk("lit_a_blank_at76", blank_a, 0);
      if (i == 80) chk("lit_a_blank_at80", blank_a, 1);
      if (i == 88) begin
        chk("lit_a_cd_at88", cd_a, 1);
        chk("lit_a_digit_at88", digit_a, 0);
      end
      if (i == 89) chk("lit_a_cd_at89", cd_a, 0);
      if (i == 12) begin
        chk("lit_b_state_at12", state_b, 1);
        chk("lit_b_blank_at12", blank_b, 1);
      end
      if (i == 16) chk("lit_b_blank_at16", blank_b, 0);
      if (i == 20) begin
        chk("lit_b_cd_at20", cd_b, 1);
        chk("lit_b_digit_at20", digit_b, 0);
      end
    end

    // Freeze during a digit-4 hold.
    w = 0;
    while (digit_a != 4'd4 && w < 200) begin
      step(1);
      w++;
    end
    chk("t3_found_digit4", digit_a, 4);
    step(1);
    en = 1'b0;
    step(10);
    chk("t3_frozen_digit", digit_a, 4);
    chk("t3_frozen_tick", tick_a, 0);
    en = 1'b1;
    step(2);
    chk("t3_still_digit4", digit_a, 4);
    step(1);
    chk("t3_next_digit5", digit_a, 5);

    // Random enable with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      step(1);
      en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    en = 1'b1;

    // Reset in the middle of a blank PAUSE phase.
    w = 0;
    while (!(state_a == 1'b1 && blank_a == 1'b1) && w < 400) begin
      step(1);
      w++;
    end
    chk("t4_found_pause_blank", int'(state_a && blank_a), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t4_digit", digit_a, 0);
    chk("t4_blank", blank_a, 0);
    chk("t4_state", state_a, 0);
    chk("t4_lap", lap_a, 0);
    chk("t4_cd", cd_a, 0);
    step(4);
    chk("t4_restart_digit2", digit_a, 2);

    // Reset while disabled, then first tick timing after enable.
    step(7);
    en = 1'b0;
    reset = 1'b1;
    step(1);
    chk("t6_digit_a", digit_a, 0);
    chk("t6_tick_a", tick_a, 0);
    reset = 1'b0;
    step(3);
    chk("t6_hold_digit", digit_a, 0);
    en = 1'b1;
    chk("t6_tick_a_en0", tick_a, 0);
    chk("t6_tick_b_en0", tick_b, 0);
    step(1);
    chk("t6_tick_b_first", tick_b, 1);
    chk("t6_tick_a_1", tick_a, 0);
    step(2);
    chk("t6_tick_a_first", tick_a, 1);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
